// File: rtl/pulseox_seq_ctrl.sv
// Pulse-ox sample buffer sequencer: runs the AFE diagnostic with retries and a timeout,
// then streams while watchdogging the new-sample strobe and framing samples.
module pulseox_seq_ctrl #(
  parameter int DIAG_RETRIES   = 3,
  parameter int DIAG_TIMEOUT   = 64,
  parameter int SAMPLE_TIMEOUT = 500000,
  parameter int FRAME_LEN      = 256,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic             in_stop,
  input  logic [1:0]       in_diag_er,
  input  logic             in_new_samples,
  output logic [1:0]       out_data_control,
  output logic [CNT_W-1:0] out_sample_cnt,
  output logic             out_frame_dv,
  output logic [7:0]       out_status,
  output logic             out_fault
);
  localparam int DT_W = $clog2(DIAG_TIMEOUT + 1);
  localparam int WD_W = $clog2(SAMPLE_TIMEOUT + 1);
  localparam int FC_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DIAG_CLR  = 3'd1,
    DIAG_WAIT = 3'd2,
    STREAM    = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t           state, state_n;
  logic             start_q, ns_q;
  logic [3:0]       retry_cnt, retry_n;
  logic [4:0]       retry_inc;
  logic [DT_W-1:0]  diag_tmr, diag_tmr_n;
  logic [WD_W-1:0]  wd_tmr, wd_tmr_n;
  logic [FC_W-1:0]  frame_cnt, frame_n;
  logic [CNT_W-1:0] sample_n;
  logic             fault_n, frame_dv_n;
  logic [1:0]       cause, cause_n, ctrl_n;
  logic             start_rise, ns_rise, diag_pass, diag_err, diag_tmo;

  assign start_rise = in_start & ~start_q;
  assign ns_rise    = in_new_samples & ~ns_q;
  assign diag_pass  = (in_diag_er == 2'b10);
  assign diag_err   = in_diag_er[0];
  assign diag_tmo   = (diag_tmr == DT_W'(DIAG_TIMEOUT - 1));
  assign retry_inc  = {1'b0, retry_cnt} + 5'd1;

  always_comb begin
    state_n    = state;
    retry_n    = retry_cnt;
    diag_tmr_n = diag_tmr;
    wd_tmr_n   = wd_tmr;
    frame_n    = frame_cnt;
    sample_n   = out_sample_cnt;
    frame_dv_n = 1'b0;
    fault_n    = out_fault;
    cause_n    = cause;
    case (state)
      IDLE: begin
        if (start_rise && !in_stop) begin
          state_n = DIAG_CLR;
          retry_n = '0;
        end
      end
      DIAG_CLR: begin
        if (in_stop) state_n = IDLE;
        else begin
          diag_tmr_n = '0;
          state_n    = DIAG_WAIT;
        end
      end
      DIAG_WAIT: begin
        diag_tmr_n = diag_tmr + DT_W'(1);
        if (in_stop) state_n = IDLE;
        else if (diag_pass) begin
          state_n  = STREAM;
          sample_n = '0;
          frame_n  = '0;
          wd_tmr_n = '0;
        end else if (diag_err || diag_tmo) begin
          // an explicit verdict outranks a coincident timeout when naming the cause
          retry_n = retry_inc[3:0];
          if (retry_inc < 5'(DIAG_RETRIES)) state_n = DIAG_CLR;
          else begin
            state_n = FAULT;
            fault_n = 1'b1;
            cause_n = diag_err ? 2'b01 : 2'b10;
          end
        end
      end
      STREAM: begin
        if (in_stop) state_n = IDLE;
        else if (ns_rise) begin
          sample_n = out_sample_cnt + CNT_W'(1);
          wd_tmr_n = '0;
          if (frame_cnt == FC_W'(FRAME_LEN - 1)) begin
            frame_n    = '0;
            frame_dv_n = 1'b1;
          end else frame_n = frame_cnt + FC_W'(1);
        end else if (wd_tmr == WD_W'(SAMPLE_TIMEOUT - 1)) begin
          state_n = FAULT;
          fault_n = 1'b1;
          cause_n = 2'b11;
        end else wd_tmr_n = wd_tmr + WD_W'(1);
      end
      FAULT: begin
        if (start_rise) begin
          state_n = DIAG_CLR;
          fault_n = 1'b0;
          cause_n = 2'b00;
          retry_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    ctrl_n = 2'b00;
    if (state_n == DIAG_WAIT) ctrl_n = 2'b01;
    if (state_n == STREAM)    ctrl_n = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state            <= IDLE;
      start_q          <= 1'b0;
      ns_q             <= 1'b0;
      retry_cnt        <= '0;
      diag_tmr         <= '0;
      wd_tmr           <= '0;
      frame_cnt        <= '0;
      cause            <= 2'b00;
      out_data_control <= 2'b00;
      out_sample_cnt   <= '0;
      out_frame_dv     <= 1'b0;
      out_fault        <= 1'b0;
      out_status       <= 8'h00;
    end else begin
      state            <= state_n;
      start_q          <= in_start;
      ns_q             <= in_new_samples;
      retry_cnt        <= retry_n;
      diag_tmr         <= diag_tmr_n;
      wd_tmr           <= wd_tmr_n;
      frame_cnt        <= frame_n;
      cause            <= cause_n;
      out_data_control <= ctrl_n;
      out_sample_cnt   <= sample_n;
      out_frame_dv     <= frame_dv_n;
      out_fault        <= fault_n;
      out_status       <= {2'b00, cause_n, fault_n, state_n};
    end
  end
endmodule

// File: tb/tb_pulseox_seq_ctrl.sv
// Bench for pulseox_seq_ctrl: fixed vectors, directed corner sequences and a
// randomized run against an abstract cycle model.
module tb_pulseox_seq_ctrl;
  localparam int RETRIES = 3;
  localparam int DTO     = 64;
  localparam int STO     = 100;
  localparam int FLEN    = 4;

  logic        clk = 1'b0;
  logic        in_reset = 1'b1, in_start = 1'b0, in_stop = 1'b0, in_new_samples = 1'b0;
  logic [1:0]  in_diag_er = 2'b00;
  logic [1:0]  out_data_control;
  logic [15:0] out_sample_cnt;
  logic        out_frame_dv, out_fault;
  logic [7:0]  out_status;

  int checks = 0, errors = 0;

  pulseox_seq_ctrl #(.DIAG_RETRIES(RETRIES), .DIAG_TIMEOUT(DTO), .SAMPLE_TIMEOUT(STO),
                     .FRAME_LEN(FLEN), .CNT_W(16)) dut (
    .clk(clk), .in_reset(in_reset), .in_start(in_start), .in_stop(in_stop),
    .in_diag_er(in_diag_er), .in_new_samples(in_new_samples),
    .out_data_control(out_data_control), .out_sample_cnt(out_sample_cnt),
    .out_frame_dv(out_frame_dv), .out_status(out_status), .out_fault(out_fault));

  always #5 clk = ~clk;

  // Abstract model: mode as a number, attempts made, cycles waited, quiet cycles, samples.
  int m_mode = 0, m_attempts = 0, m_waited = 0, m_quiet = 0, m_samples = 0, m_in_frame = 0;
  int m_cause = 0;
  bit m_fault = 0, m_dv = 0, m_prev_start = 0, m_prev_ns = 0;

  task automatic model_step(input bit st, input bit sp, input bit [1:0] de, input bit ns, input bit rs);
    bit rise_s, rise_n;
    if (rs) begin
      m_mode = 0; m_attempts = 0; m_waited = 0; m_quiet = 0; m_samples = 0; m_in_frame = 0;
      m_cause = 0; m_fault = 0; m_dv = 0; m_prev_start = 0; m_prev_ns = 0;
      return;
    end
    rise_s = st && !m_prev_start;
    rise_n = ns && !m_prev_ns;
    m_prev_start = st;
    m_prev_ns = ns;
    m_dv = 0;
    if (m_mode == 4) begin
      if (rise_s) begin m_mode = 1; m_fault = 0; m_cause = 0; m_attempts = 0; end
    end else if (sp) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (rise_s) begin m_mode = 1; m_attempts = 0; end
    end else if (m_mode == 1) begin
      m_waited = 0; m_mode = 2;
    end else if (m_mode == 2) begin
      if (de == 2'b10) begin
        m_mode = 3; m_samples = 0; m_in_frame = 0; m_quiet = 0;
      end else if (de[0] || m_waited == DTO - 1) begin
        m_attempts++;
        if (m_attempts >= RETRIES) begin
          m_mode = 4; m_fault = 1; m_cause = de[0] ? 1 : 2;
        end else m_mode = 1;
      end else m_waited++;
    end else begin
      if (rise_n) begin
        m_samples++; m_in_frame++; m_quiet = 0;
        if (m_in_frame == FLEN) begin m_in_frame = 0; m_dv = 1; end
      end else if (m_quiet == STO - 1) begin
        m_mode = 4; m_fault = 1; m_cause = 3;
      end else m_quiet++;
    end
  endtask

  function automatic logic [27:0] model_outs();
    logic [1:0] c;
    logic [7:0] s;
    c = (m_mode == 2) ? 2'b01 : (m_mode == 3) ? 2'b10 : 2'b00;
    s = {2'b00, 2'(m_cause), m_fault, 3'(m_mode)};
    return {c, 16'(m_samples), m_dv, s, m_fault};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit st, input bit sp, input bit [1:0] de, input bit ns, input bit rs);
    in_start = st; in_stop = sp; in_diag_er = de; in_new_samples = ns; in_reset = rs;
    @(posedge clk);
    model_step(st, sp, de, ns, rs);
    #1;
    chk("model", {out_data_control, out_sample_cnt, out_frame_dv, out_status, out_fault}, model_outs());
  endtask

  task automatic enter_stream();
    cyc(0, 1, 2'b00, 0, 0);
    cyc(1, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b10, 0, 0);
  endtask

  typedef struct {
    bit st, sp; bit [1:0] de; bit ns;
    logic [1:0] e_ctrl; logic [7:0] e_status; logic e_fault;
  } vec_t;

  vec_t vt[7];

  initial begin
    int c01, rises, sc, dv_n;
    logic [1:0] prev_c;
    int dv_at[4];
    bit ns_lvl;

    vt[0] = '{1, 0, 2'b00, 0, 2'b00, 8'h01, 0};
    vt[1] = '{1, 0, 2'b00, 0, 2'b01, 8'h02, 0};
    vt[2] = '{1, 0, 2'b00, 0, 2'b01, 8'h02, 0};
    vt[3] = '{0, 0, 2'b00, 0, 2'b01, 8'h02, 0};
    vt[4] = '{0, 0, 2'b10, 0, 2'b10, 8'h03, 0};
    vt[5] = '{0, 0, 2'b00, 0, 2'b10, 8'h03, 0};
    vt[6] = '{0, 1, 2'b00, 0, 2'b00, 8'h00, 0};

    cyc(0, 0, 2'b00, 0, 1);
    cyc(0, 0, 2'b00, 0, 1);
    chk("reset_outs", {out_data_control, out_sample_cnt, out_frame_dv, out_status, out_fault}, 28'h0);

    for (int i = 0; i < 7; i++) begin
      cyc(vt[i].st, vt[i].sp, vt[i].de, vt[i].ns, 0);
      chk($sformatf("vec%0d_ctrl", i), out_data_control, vt[i].e_ctrl);
      chk($sformatf("vec%0d_status", i), out_status, vt[i].e_status);
      chk($sformatf("vec%0d_fault", i), out_fault, vt[i].e_fault);
    end

    // every attempt reports an error verdict
    cyc(0, 0, 2'b01, 0, 0);
    cyc(1, 0, 2'b01, 0, 0);
    prev_c = out_data_control; rises = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 2'b01, 0, 0);
      if (prev_c == 2'b00 && out_data_control == 2'b01) rises++;
      prev_c = out_data_control;
    end
    chk("err_attempts", rises, RETRIES);
    chk("err_status", out_status, 8'h1C);
    chk("err_ctrl", out_data_control, 2'b00);
    chk("err_fault", out_fault, 1);

    // no verdict ever: three full-length attempts, then a timeout fault
    cyc(0, 1, 2'b00, 0, 0);
    chk("stop_keeps_fault", out_fault, 1);
    cyc(1, 0, 2'b00, 0, 0);
    chk("restart_clr_fault", out_fault, 0);
    chk("restart_state", out_status, 8'h01);
    prev_c = out_data_control; rises = 0; c01 = 0;
    for (int i = 0; i < 400 && out_status[2:0] != 3'd4; i++) begin
      cyc(0, 0, 2'b00, 0, 0);
      if (out_data_control == 2'b01) c01++;
      if (prev_c == 2'b00 && out_data_control == 2'b01) rises++;
      prev_c = out_data_control;
    end
    chk("tmo_wait_cycles", c01, RETRIES * DTO);
    chk("tmo_attempts", rises, RETRIES);
    chk("tmo_status", out_status, 8'h2C);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(1, 0, 2'b00, 0, 0);
    chk("tmo_restart_fault", out_fault, 0);
    chk("tmo_restart_state", out_status[2:0], 3'd1);

    // framing: 9 pulses, one held high for 5 cycles
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b10, 0, 0);
    chk("frm_stream", out_status[2:0], 3'd3);
    dv_n = 0;
    for (int p = 0; p < 9; p++) begin
      for (int h = 0; h < ((p == 2) ? 5 : 1) + 2; h++) begin
        cyc(0, 0, 2'b00, (h < ((p == 2) ? 5 : 1)) ? 1'b1 : 1'b0, 0);
        if (out_frame_dv) begin
          if (dv_n < 4) dv_at[dv_n] = int'(out_sample_cnt);
          dv_n++;
        end
      end
    end
    chk("frm_cnt", out_sample_cnt, 9);
    chk("frm_dv_count", dv_n, 2);
    chk("frm_dv_first", dv_at[0], 4);
    chk("frm_dv_second", dv_at[1], 8);
    cyc(0, 1, 2'b00, 0, 0);
    chk("stop_holds_cnt", out_sample_cnt, 9);
    chk("stop_ctrl", out_data_control, 2'b00);

    // sample watchdog
    enter_stream();
    sc = 0;
    for (int i = 0; i < 300 && out_status[2:0] == 3'd3; i++) begin
      sc++;
      cyc(0, 0, 2'b00, 0, 0);
    end
    chk("wd_stream_cycles", sc, STO);
    chk("wd_status", out_status, 8'h3C);
    enter_stream();
    repeat (STO - 1) cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 1, 0);
    chk("wd_edge_wins", out_status, 8'h03);
    chk("wd_edge_cnt", out_sample_cnt, 1);

    // stop beats a same-cycle pass verdict
    cyc(0, 1, 2'b00, 0, 0);
    cyc(1, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 1, 2'b10, 0, 0);
    chk("stop_vs_pass_ctrl", out_data_control, 2'b00);
    chk("stop_vs_pass_status", out_status, 8'h00);

    // reset in the middle of streaming
    enter_stream();
    cyc(0, 0, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 1, 0);
    chk("pre_rst_cnt", out_sample_cnt, 2);
    cyc(0, 0, 2'b00, 1, 1);
    chk("mid_rst_outs", {out_data_control, out_sample_cnt, out_frame_dv, out_status, out_fault}, 28'h0);

    // randomized run against the model
    ns_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit [1:0] de;
      r = $urandom_range(0, 15);
      de = (r < 10) ? 2'b00 : (r < 13) ? 2'b10 : (r < 15) ? 2'b01 : 2'b11;
      if ($urandom_range(0, 2) == 0) ns_lvl = ~ns_lvl;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, de, ns_lvl,
          $urandom_range(0, 699) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
